// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - 4-bit MDU op-code constants (MDU_NOP .. MDU_MSUBU); 11-15 decode as NOP
//   - default busy latencies for multiply-class and divide ops
//   - FSM state type and op-class helper functions
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam int MDU_DEF_MULT_CYCLES = 5;
  localparam int MDU_DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Ops that go through the multiplier and take MULT_CYCLES.
  function automatic logic is_mul_class(input logic [3:0] op);
    return (op == MDU_MULT)  || (op == MDU_MULTU) ||
           (op == MDU_MADD)  || (op == MDU_MADDU) ||
           (op == MDU_MSUB)  || (op == MDU_MSUBU);
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: combinational datapath of the multiply/divide unit.
// Computes the next HI/LO pair for a multiply-class or divide op.
// Ports:
//   op          in  4      MDU op code
//   a, b        in  WIDTH  rs / rt operands
//   hi, lo      in  WIDTH  current architectural HI/LO (accumulate base)
//   hi_n, lo_n  out WIDTH  result to be committed
//   div_by_zero out 1      divide op with b == 0
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  logic             mul_signed;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mul_res;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Multiply: extend both operands to 2*WIDTH (sign or zero) so the low
  // 2*WIDTH bits of the product are the exact signed/unsigned result.
  assign mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  assign a_ext = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi, lo};

  always_comb begin
    mul_res = prod;
    if ((op == MDU_MADD) || (op == MDU_MADDU)) begin
      mul_res = acc + prod;
    end else if ((op == MDU_MSUB) || (op == MDU_MSUBU)) begin
      mul_res = acc - prod;
    end
  end

  // Divide on magnitudes, then fix signs: quotient negative when operand
  // signs differ, remainder follows the dividend. The most-negative / -1
  // case falls out naturally: magnitude 2^(W-1) negates back to itself.
  assign div_signed = (op == MDU_DIV);
  assign a_neg  = div_signed & a[WIDTH-1];
  assign b_neg  = div_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;
  // Keep the divider defined when b is zero; that result is discarded.
  assign b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

  assign div_by_zero = is_div_class(op) && (b == '0);

  always_comb begin
    hi_n = mul_res[W2-1:WIDTH];
    lo_n = mul_res[WIDTH-1:0];
    if (is_div_class(op)) begin
      hi_n = rem;
      lo_n = quot;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// One op accepted per start pulse while idle; busy holds for the op latency,
// then the precomputed result commits to HI/LO in a single edge.
// Ports:
//   clk    in  1      clock, all state on rising edge
//   reset  in  1      synchronous, active-low
//   start  in  1      launch op this cycle (ignored while busy)
//   op     in  4      MDU op code (mdu_pkg)
//   A, B   in  WIDTH  rs / rt operands
//   busy   out 1      operation in flight
//   HI, LO out WIDTH  architectural HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_n_q, hi_n_d;
  logic [WIDTH-1:0] lo_n_q, lo_n_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_dbz;

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op          (op),
    .a           (A),
    .b           (B),
    .hi          (hi_q),
    .lo          (lo_q),
    .hi_n        (core_hi),
    .lo_n        (core_lo),
    .div_by_zero (core_dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    dbz_d   = dbz_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          if (is_mul_class(op)) begin
            state_d = MDU_RUN;
            cnt_d   = 8'(MULT_CYCLES);
            hi_n_d  = core_hi;
            lo_n_d  = core_lo;
            dbz_d   = 1'b0;
          end else if (is_div_class(op)) begin
            state_d = MDU_RUN;
            cnt_d   = 8'(DIV_CYCLES);
            hi_n_d  = core_hi;
            lo_n_d  = core_lo;
            dbz_d   = core_dbz;
          end else if (op == MDU_MTHI) begin
            hi_d = A;
          end else if (op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - 8'd1;
        // Last busy cycle: commit the shadow result (unless div-by-zero).
        if (cnt_q == 8'd1) begin
          state_d = MDU_IDLE;
          if (!dbz_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit default instance and a 16-bit
// single-cycle-multiply instance. Inputs change and outputs are sampled on
// the falling edge.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] A16, B16;
  logic        busy16;
  logic [15:0] HI16, LO16;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  mult_div_unit #(
    .WIDTH       (16),
    .MULT_CYCLES (1),
    .DIV_CYCLES  (3)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .op    (op16),
    .A     (A16),
    .B     (B16),
    .busy  (busy16),
    .HI    (HI16),
    .LO    (LO16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; issues one op and returns at the falling edge
  // of the first idle cycle, reporting how many cycles busy was seen high.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_cyc, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int cyc;
    logic [31:0] hi_before;
    logic [31:0] lo_before;
    hi_before = HI;
    lo_before = LO;
    run_op(o, a, b, cyc);
    check_val({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check_val({tag, " HI"}, 64'(HI), 64'(exp_hi));
    check_val({tag, " LO"}, 64'(LO), 64'(exp_lo));
    $display("op=%0d A=0x%08h B=0x%08h : HI 0x%08h->0x%08h LO 0x%08h->0x%08h busy=%0d",
             o, a, b, hi_before, HI, lo_before, LO, cyc);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = MDU_NOP;
    A       = '0;
    B       = '0;
    start16 = 1'b0;
    op16    = MDU_NOP;
    A16     = '0;
    B16     = '0;

    repeat (2) @(negedge clk);
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset HI", 64'(HI), 64'd0);
    check_val("reset LO", 64'(LO), 64'd0);
    check_val("reset busy16", 64'(busy16), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Moves to HI/LO: one edge, no busy.
    do_op("MTHI", MDU_MTHI, 32'h1234, 32'h0, 0, 32'h1234, 32'h0);
    do_op("MTLO", MDU_MTLO, 32'h5678, 32'h0, 0, 32'h1234, 32'h5678);

    // Multiply / divide
    do_op("MULT -1*2", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("MULTU ffffffff*2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);
    do_op("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("DIVU 7/0", MDU_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("DIV 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD);
    do_op("DIVU fffffff9/2", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'h7FFF_FFFC);
    do_op("DIV ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // Accumulate
    do_op("MTHI 0", MDU_MTHI, 32'h0, 32'h0, 0, 32'h0, 32'h8000_0000);
    do_op("MTLO 10", MDU_MTLO, 32'd10, 32'h0, 0, 32'h0, 32'd10);
    do_op("MADDU 3*4", MDU_MADDU, 32'd3, 32'd4, 5, 32'h0, 32'd22);
    do_op("MSUB 5*5", MDU_MSUB, 32'd5, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("MADD -1*3", MDU_MADD, 32'hFFFF_FFFF, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("MSUBU 2*3", MDU_MSUBU, 32'd2, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    // start held high with changing operands while busy: only the first
    // MULTU (3*5) may commit; HI/LO hold old values throughout RUN.
    op    = MDU_MULTU;
    A     = 32'd3;
    B     = 32'd5;
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_val("pulse busy", 64'(busy), 64'd1);
      check_val("pulse LO hold", 64'(LO), 64'hFFFF_FFF4);
      A = 32'd100 + 32'(i);
      B = 32'd100;
    end
    @(negedge clk);
    start = 1'b0;
    check_val("pulse busy fall", 64'(busy), 64'd0);
    check_val("pulse HI", 64'(HI), 64'h0);
    check_val("pulse LO", 64'(LO), 64'd15);
    $display("op=%0d A=0x%08h B=0x%08h : HI 0x%08h LO 0x%08h (repeated start)", MDU_MULTU,
             32'd3, 32'd5, HI, LO);
    repeat (7) @(negedge clk);
    check_val("pulse no late commit", 64'(LO), 64'd15);

    // Back-to-back issue in the first idle cycle.
    do_op("B2B MULTU 6*7", MDU_MULTU, 32'd6, 32'd7, 5, 32'h0, 32'd42);
    do_op("B2B MULTU 8*9", MDU_MULTU, 32'd8, 32'd9, 5, 32'h0, 32'd72);

    // Reset during DIV cycle 4 of 10.
    op    = MDU_DIV;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid-div busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check_val("mid-div reset busy", 64'(busy), 64'd0);
    check_val("mid-div reset HI", 64'(HI), 64'd0);
    check_val("mid-div reset LO", 64'(LO), 64'd0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check_val("mid-div no commit busy", 64'(busy), 64'd0);
    check_val("mid-div no commit LO", 64'(LO), 64'd0);
    $display("DIV 100/7 aborted by reset: HI 0x%08h LO 0x%08h", HI, LO);

    // Reset wins over a start on the same edge.
    op    = MDU_MTHI;
    A     = 32'h55;
    start = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    check_val("reset vs MTHI", 64'(HI), 64'd0);
    $display("MTHI 0x55 with reset: HI 0x%08h", HI);

    // 16-bit, single-cycle multiply.
    op16    = MDU_MULT;
    A16     = 16'h8000;
    B16     = 16'h8000;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check_val("w16 busy", 64'(busy16), 64'd1);
    check_val("w16 HI hold", 64'(HI16), 64'd0);
    @(negedge clk);
    check_val("w16 busy fall", 64'(busy16), 64'd0);
    check_val("w16 HI", 64'(HI16), 64'h4000);
    check_val("w16 LO", 64'(LO16), 64'h0);
    $display("w16 MULT 0x8000*0x8000 : HI 0x%04h LO 0x%04h", HI16, LO16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
